// File: rtl/mips_pkg.sv
// mips_pkg: shared MDU op/state encodings, alu control codes and carry helpers.
package mips_pkg;
  typedef enum logic [1:0] {MULT = 2'd0, MULTU = 2'd1, DIV = 2'd2, DIVU = 2'd3} mdu_op_t;
  typedef enum logic [2:0] {IDLE, NEGA, NEGB, ITER, FIXLO, FIXHI} mdu_state_t;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b1010;
  localparam logic [3:0] ALU_ORN = 4'b1001;
  // The shared alu has no carry-out, so carry/borrow is rebuilt from the sign bits.
  function automatic logic add_carry(input logic a31, input logic b31, input logic y31);
    return (a31 & b31) | ((a31 | b31) & ~y31);
  endfunction
  function automatic logic sub_no_borrow(input logic a31, input logic b31, input logic y31);
    return (a31 & ~b31) | ((a31 | ~b31) & ~y31);
  endfunction
endpackage

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative MULT/DIV sequencer owning HI/LO; all arithmetic goes through the shared alu.
module mdu_ctrl
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             mfhi,
  input  logic             mflo,
  input  logic [WIDTH-1:0] alu_y,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_f,
  output logic             alu_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done
);
  mdu_state_t       state_q, state_d;
  logic             mul_q, mul_d, sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, q_q, q_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH:0]   r_q, r_d, r_sh;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] b_abs;
  logic             take, neg_lo, neg_hi, k_zero;
  mdu_op_t          op_in;

  assign op_in   = mdu_op_t'(op);
  assign busy    = state_q != IDLE;
  assign alu_req = busy;
  assign stall   = busy & (start | mfhi | mflo | mthi | mtlo);
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign r_sh    = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign b_abs   = sb_q ? alu_y : b_q;
  assign take    = r_sh[WIDTH] | sub_no_borrow(r_sh[WIDTH-1], b_q[WIDTH-1], alu_y[WIDTH-1]);
  assign neg_lo  = (sa_q ^ sb_q) & (mul_q | ~dz_q);
  assign neg_hi  = mul_q ? sa_q ^ sb_q : sa_q;
  assign k_zero  = q_q == '0;

  always_comb begin
    state_d = state_q;
    mul_d   = mul_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    a_d     = a_q;
    b_d     = b_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    alu_a   = '0;
    alu_b   = '0;
    alu_f   = ALU_ADD;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mthi || mtlo) begin
          hi_d = mthi ? srca : hi_q;
          lo_d = mtlo ? srca : lo_q;
        end else if (start) begin
          state_d = NEGA;
          mul_d   = op_in inside {MULT, MULTU};
          sa_d    = (op_in inside {MULT, DIV}) & srca[WIDTH-1];
          sb_d    = (op_in inside {MULT, DIV}) & srcb[WIDTH-1];
          dz_d    = srcb == '0;
          a_d     = srca;
          b_d     = srcb;
        end
      end
      NEGA: begin
        alu_f   = ALU_SUB;
        alu_b   = a_q;
        a_d     = sa_q ? alu_y : a_q;
        state_d = NEGB;
      end
      NEGB: begin
        alu_f   = ALU_SUB;
        alu_b   = b_q;
        b_d     = b_abs;
        q_d     = mul_q ? b_abs : a_q;
        r_d     = '0;
        cnt_d   = '0;
        state_d = ITER;
      end
      ITER: begin
        if (mul_q) begin
          alu_a = r_q[WIDTH-1:0];
          alu_b = q_q[0] ? a_q : '0;
          r_d   = {1'b0, add_carry(r_q[WIDTH-1], q_q[0] & a_q[WIDTH-1], alu_y[WIDTH-1]), alu_y[WIDTH-1:1]};
          q_d   = {alu_y[0], q_q[WIDTH-1:1]};
        end else begin
          alu_f = ALU_SUB;
          alu_a = r_sh[WIDTH-1:0];
          alu_b = b_q;
          r_d   = take ? {1'b0, alu_y} : r_sh;
          q_d   = {q_q[WIDTH-2:0], take};
        end
        cnt_d   = cnt_q + 5'd1;
        state_d = (cnt_q == 5'(ITERS - 1)) ? FIXLO : ITER;
      end
      FIXLO: begin
        alu_f   = ALU_SUB;
        alu_b   = q_q;
        q_d     = neg_lo ? alu_y : q_q;
        state_d = FIXHI;
      end
      FIXHI: begin
        // A negated 64-bit product only borrows into HI when LO is zero.
        alu_f   = (mul_q && !k_zero) ? ALU_ORN : ALU_SUB;
        alu_b   = r_q[WIDTH-1:0];
        hi_d    = neg_hi ? alu_y : r_q[WIDTH-1:0];
        lo_d    = q_q;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mul_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      mul_q   <= mul_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed-vector bench for mdu_ctrl with a behavioural alu in the loop.
module tb_mdu_ctrl;
  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, flush = 1'b0;
  logic        mthi = 1'b0, mtlo = 1'b0, mfhi = 1'b0, mflo = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] srca = '0, srcb = '0, alu_y, alu_a, alu_b, hi, lo;
  logic [3:0]  alu_f;
  logic        alu_req, busy, stall, done;
  int          checks = 0, errors = 0;

  mdu_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .flush(flush), .mthi(mthi), .mtlo(mtlo), .mfhi(mfhi), .mflo(mflo),
    .alu_y(alu_y), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_req(alu_req),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  always_comb
    alu_y = (alu_f == 4'b0010) ? alu_a + alu_b :
            (alu_f == 4'b1010) ? alu_a - alu_b :
            (alu_f == 4'b1001) ? (alu_a | ~alu_b) : 32'h0;

  task automatic test_reset;
    #2;
    checks++;
    if ({hi, lo} !== 64'h0 || {busy, stall, done, alu_req} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_regs: hi=%h lo=%h busy/stall/done/req=%b, required all zero", hi, lo, {busy, stall, done, alu_req});
    end
    checks++;
    if (alu_a !== 32'h0 || alu_b !== 32'h0 || alu_f !== 4'b0010) begin
      errors++;
      $display("FAIL reset_alu: a=%h b=%h f=%b, required 0 0 0010", alu_a, alu_b, alu_f);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string nm);
    int   done_k, ndone;
    logic stall_ok;
    done_k = -1; ndone = 0; stall_ok = 1'b1;
    @(negedge clk);
    op = o; srca = a; srcb = b; start = 1'b1; mflo = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin ndone++; done_k = k; end
      if (stall !== 1'(k <= 36)) stall_ok = 1'b0;
      start = 1'b0;
    end
    mflo = 1'b0;
    checks++;
    if (done_k != 36 || ndone != 1) begin
      errors++;
      $display("FAIL %s_done: last done at cycle %0d, %0d pulses; required cycle 36, 1 pulse", nm, done_k, ndone);
    end
    checks++;
    if (!stall_ok) begin
      errors++;
      $display("FAIL %s_stall: stall not high exactly on cycles 1..36 while mflo held", nm);
    end
    checks++;
    if (hi !== exp_hi) begin
      errors++;
      $display("FAIL %s_hi: got %h, required %h", nm, hi, exp_hi);
    end
    checks++;
    if (lo !== exp_lo) begin
      errors++;
      $display("FAIL %s_lo: got %h, required %h", nm, lo, exp_lo);
    end
  endtask

  task automatic test_multu;
    run_op(2'd1, 32'd7, 32'd6, 32'h0, 32'd42, "multu_7x6");
    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
  endtask

  task automatic test_mult;
    run_op(2'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult_m3x5");
    run_op(2'd0, 32'h00010000, 32'hFFFF0000, 32'hFFFFFFFF, 32'h00000000, "mult_lozero");
  endtask

  task automatic test_div;
    run_op(2'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7d2");
    run_op(2'd2, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7dm2");
    run_op(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100d7");
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, "div_intmin");
    run_op(2'd3, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF, "divu_zero");
  endtask

  task automatic test_mt;
    @(negedge clk); mthi = 1'b1; srca = 32'hAA;
    @(negedge clk); mthi = 1'b0; mtlo = 1'b1; srca = 32'hBB;
    @(negedge clk); mtlo = 1'b0;
    checks++;
    if (hi !== 32'hAA || lo !== 32'hBB) begin
      errors++;
      $display("FAIL mt_write: hi=%h lo=%h, required 000000aa 000000bb", hi, lo);
    end
    start = 1'b1; mthi = 1'b1; op = 2'd3; srca = 32'hCC; srcb = 32'd3;
    @(negedge clk); start = 1'b0; mthi = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'hCC) begin
      errors++;
      $display("FAIL mt_beats_start: busy=%b hi=%h, required 0 000000cc", busy, hi);
    end
    mthi = 1'b1; srca = 32'hAA;
    @(negedge clk); mthi = 1'b0;
  endtask

  task automatic test_flush;
    int ndone;
    ndone = 0;
    start = 1'b1; op = 2'd3; srca = 32'd100; srcb = 32'd7;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) ndone++;
      if (k == 11) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL flush_idle: busy=%b one cycle after flush, required 0", busy);
        end
      end
      flush = (k == 10);
    end
    checks++;
    if (ndone != 0 || hi !== 32'hAA || lo !== 32'hBB) begin
      errors++;
      $display("FAIL flush_keep: done pulses=%0d hi=%h lo=%h, required 0 000000aa 000000bb", ndone, hi, lo);
    end
  endtask

  task automatic test_reset_mid;
    int ndone;
    ndone = 0;
    start = 1'b1; op = 2'd3; srca = 32'd100; srcb = 32'd7;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) ndone++;
      if (k == 20) begin
        reset = 1'b0;
        #1;
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL reset_mid: hi=%h lo=%h busy=%b, required 0 0 0", hi, lo, busy);
        end
      end
      if (k == 21) reset = 1'b1;
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL reset_mid_done: %0d done pulses after abort, required 0", ndone);
    end
  endtask

  initial begin
    test_reset;
    test_multu;
    test_mult;
    test_div;
    test_mt;
    test_flush;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
